// File: rtl/iir_pkg.sv
// Shared definitions for the biquad IIR filter and its SPI coefficient loader.
package iir_pkg;
  localparam int unsigned COEFF_W    = 16;
  localparam int unsigned NUM_COEFFS = 5;
  localparam int unsigned FRAME_BITS = COEFF_W * NUM_COEFFS;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  localparam coeff_t Q2_14_ONE = 16'sh4000;

  typedef struct packed {
    coeff_t b0;
    coeff_t b1;
    coeff_t b2;
    coeff_t a1;
    coeff_t a2;
  } coeff_set_t;

  // Pass-through filter: b0 = 1.0, everything else zero.
  localparam coeff_set_t UNITY_SET = '{b0: Q2_14_ONE, b1: '0, b2: '0, a1: '0, a2: '0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } loader_state_t;
endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/spi_coeff_loader.sv
// SPI target receiving five-word biquad coefficient frames; validated frames are
// staged in a shadow set and committed atomically on the next sample tick.
module spi_coeff_loader
  import iir_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = NUM_COEFFS,
  parameter int unsigned COEFF_W     = iir_pkg::COEFF_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sck,
  input  logic                      cs_n,
  input  logic                      mosi,
  input  logic                      sample_tick,
  output logic signed [COEFF_W-1:0] b0,
  output logic signed [COEFF_W-1:0] b1,
  output logic signed [COEFF_W-1:0] b2,
  output logic signed [COEFF_W-1:0] a1,
  output logic signed [COEFF_W-1:0] a2,
  output logic                      coeff_updated,
  output logic                      frame_error,
  output logic                      pending
);
  localparam logic [6:0] FULL_CNT = 7'(FRAME_WORDS * COEFF_W);
  localparam logic [6:0] SAT_CNT  = 7'(FRAME_WORDS * COEFF_W + 1);

  logic sck_s, cs_s, mosi_s;
  logic sck_d, cs_d;
  logic sck_rise, cs_rise, cs_fall;
  logic armed;
  logic [1:0] settle;
  logic [6:0] bit_cnt;
  logic [FRAME_BITS-1:0] rx;
  loader_state_t state;
  coeff_set_t shadow, active;

  sync_2ff #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset(reset), .d(cs_n), .q(cs_s));
  sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

  // A frame already in progress at reset release must be ignored, so a falling
  // edge only counts once cs_n has been genuinely observed high after the
  // synchroniser has flushed its reset value.
  assign sck_rise = sck_s & ~sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = armed & cs_d & ~cs_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      rx            <= '0;
      sck_d         <= 1'b0;
      cs_d          <= 1'b1;
      armed         <= 1'b0;
      settle        <= '0;
      shadow        <= UNITY_SET;
      active        <= UNITY_SET;
      pending       <= 1'b0;
      coeff_updated <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      sck_d         <= sck_s;
      cs_d          <= cs_s;
      coeff_updated <= 1'b0;
      frame_error   <= 1'b0;

      if (settle != 2'd3) settle <= settle + 2'd1;
      else if (cs_s)      armed  <= 1'b1;

      // Commit precedes the shadow load so a same-cycle CHECK keeps pending set
      // and the commit takes the previous shadow.
      if (sample_tick && pending) begin
        active        <= shadow;
        pending       <= 1'b0;
        coeff_updated <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_RECV;
            bit_cnt <= '0;
          end
        end
        ST_RECV: begin
          if (cs_rise) begin
            state <= ST_CHECK;
          end else if (sck_rise) begin
            rx <= {rx[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt != SAT_CNT) bit_cnt <= bit_cnt + 7'd1;
          end
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (bit_cnt == FULL_CNT) begin
            shadow  <= coeff_set_t'(rx);
            pending <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign b0 = active.b0;
  assign b1 = active.b1;
  assign b2 = active.b2;
  assign a1 = active.a1;
  assign a2 = active.a2;
endmodule

// File: tb/tb_spi_coeff_loader.sv
// Self-checking bench for spi_coeff_loader: directed SPI frames against a
// transaction-level model of staging, commit and rejection.
module tb_spi_coeff_loader;
  import iir_pkg::*;

  logic clk = 1'b0;
  logic reset, sck, cs_n, mosi, sample_tick;
  logic signed [15:0] b0, b1, b2, a1, a2;
  logic coeff_updated, frame_error, pending;

  int checks = 0;
  int failures = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_coeff_loader #(.FRAME_WORDS(5), .COEFF_W(16)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .sample_tick(sample_tick), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
    .coeff_updated(coeff_updated), .frame_error(frame_error), .pending(pending)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a frame's outcome lands 4 clk after its cs_n pin rise; a tick with
  // something pending commits on its own edge.
  typedef struct {
    int unsigned due;
    int          len;
    logic [79:0] data;
  } ev_t;

  ev_t evq[$];
  int unsigned cyc = 0;
  coeff_set_t m_active, m_shadow;
  logic m_pending, m_upd, m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active  = UNITY_SET;
      m_shadow  = UNITY_SET;
      m_pending = 1'b0;
      m_upd     = 1'b0;
      m_err     = 1'b0;
    end else begin
      cyc++;
      m_upd = 1'b0;
      m_err = 1'b0;
      if (sample_tick && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
        m_upd     = 1'b1;
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev_t e;
        e = evq.pop_front();
        if (e.len == 80) begin
          m_shadow  = coeff_set_t'(e.data);
          m_pending = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    check("cycle", {b0, b1, b2, a1, a2, pending, coeff_updated, frame_error},
          {m_active, m_pending, m_upd, m_err});
    if (coeff_updated) upd_cnt++;
    if (frame_error)   err_cnt++;
  end

  function automatic logic [79:0] mk(input logic [15:0] w0, w1, w2, w3, w4);
    return {w0, w1, w2, w3, w4};
  endfunction

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // nbits may exceed 80 (extra bits are ones); rst_at >= 0 pulses reset before
  // that bit index; tick_after >= 0 pulses sample_tick that many clk after cs_n rise.
  task automatic send_frame(input logic [79:0] data, input int nbits,
                            input int rst_at, input int tick_after);
    bit live = 1'b1;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == rst_at) begin
        reset = 1'b0;
        live  = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
      end
      mosi = (i < 80) ? data[i] : 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    if (live) evq.push_back('{due: cyc + 4, len: nbits, data: data});
    if (tick_after >= 0) begin
      repeat (tick_after) @(negedge clk);
      tick();
    end
  endtask

  initial begin
    int u0, e0, lat;
    reset = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_b0", {b0}, 16'h4000);
    check("rst_rest", {b1, b2, a1, a2}, 64'h0);
    check("rst_flags", {pending, coeff_updated, frame_error}, 3'b000);
    reset = 1'b1;
    repeat (8) @(negedge clk);

    // Rejected frames: 79, 81 and 0 bits
    e0 = err_cnt;
    send_frame(mk(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234), 79, -1, -1);
    repeat (8) @(negedge clk);
    send_frame(mk(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234), 81, -1, -1);
    repeat (8) @(negedge clk);
    send_frame('0, 0, -1, -1);
    repeat (8) @(negedge clk);
    check("short_err_cnt", err_cnt - e0, 3);
    check("short_pending", {pending}, 1'b0);
    tick();
    repeat (2) @(negedge clk);
    check("short_b0", {b0}, 16'h4000);
    check("short_upd", upd_cnt, 0);

    // Valid frame, pending latency, commit
    send_frame(mk(16'h2000, 16'h1000, 16'h0800, 16'hC000, 16'h0400), 80, -1, -1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (pending) begin
        lat = n;
        break;
      end
    end
    check("pend_latency", lat, 4);
    repeat (3) @(negedge clk);
    tick();
    check("commit_upd", {coeff_updated}, 1'b1);
    check("commit_set", {b0, b1, b2, a1, a2}, 80'h2000_1000_0800_C000_0400);
    repeat (2) @(negedge clk);
    check("commit_upd_cnt", upd_cnt, 1);

    // Back-to-back frames, latest wins
    u0 = upd_cnt;
    send_frame(mk(16'h1111, 16'h1112, 16'h1113, 16'h1114, 16'h1115), 80, -1, -1);
    repeat (8) @(negedge clk);
    send_frame(mk(16'h2222, 16'h2223, 16'h2224, 16'h2225, 16'h2226), 80, -1, -1);
    repeat (8) @(negedge clk);
    tick();
    repeat (4) @(negedge clk);
    check("b2b_set", {b0, b1, b2, a1, a2}, 80'h2222_2223_2224_2225_2226);
    check("b2b_upd", upd_cnt - u0, 1);

    // Same-cycle collision of CHECK and commit tick
    send_frame(mk(16'h3333, 16'h3334, 16'h3335, 16'h3336, 16'h3337), 80, -1, -1);
    repeat (8) @(negedge clk);
    send_frame(mk(16'h4444, 16'h4445, 16'h4446, 16'h4447, 16'h4448), 80, -1, 3);
    check("coll_first", {b0, b1, b2, a1, a2}, 80'h3333_3334_3335_3336_3337);
    check("coll_pending", {pending}, 1'b1);
    repeat (4) @(negedge clk);
    tick();
    check("coll_second", {b0, b1, b2, a1, a2}, 80'h4444_4445_4446_4447_4448);

    // Reset after 40 bits; tail ignored; next frame accepted
    e0 = err_cnt;
    send_frame(mk(16'h5555, 16'h5556, 16'h5557, 16'h5558, 16'h5559), 80, 39, -1);
    repeat (10) @(negedge clk);
    check("mid_rst_set", {b0, b1, b2, a1, a2}, 80'h4000_0000_0000_0000_0000);
    check("mid_rst_err", err_cnt - e0, 0);
    check("mid_rst_pending", {pending}, 1'b0);
    send_frame(mk(16'h6666, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001), 80, -1, -1);
    repeat (8) @(negedge clk);
    tick();
    check("after_rst_set", {b0, b1, b2, a1, a2}, 80'h6666_8000_7FFF_FFFF_0001);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_coeff_loader.md
# spi_coeff_loader

SPI target that receives biquad coefficient sets from the MCU and drives the `b0, b1, b2, a1, a2` inputs of the IIR filter.
- A frame is five 16-bit Q2.14 words, sent MSB-first.
- Each frame is validated on chip-select release and staged in a shadow set.
- The shadow set is committed atomically to the active outputs on the next sample tick, so the filter never sees a half-updated coefficient set.

## Interface
- `FRAME_WORDS`, 5: coefficient words per frame, in order b0, b1, b2, a1, a2.
- `COEFF_W`, 16: coefficient width (Q2.14).
- `clk` in 1: system clock (filter clock).
- `reset` in 1: asynchronous, active-low reset; one clock domain only.
- `sck` in 1: SPI clock from the MCU (asynchronous to `clk`); mode 0.
- `cs_n` in 1: SPI chip select, active-low (asynchronous).
- `mosi` in 1: SPI data, sampled on the rising edge of `sck`.
- `sample_tick` in 1: one-`clk` pulse per audio sample; the commit point.
- `b0, b1, b2, a1, a2` out 16 signed each: active coefficients, registered.
- `coeff_updated` out 1: one-cycle pulse on the cycle the active set changes.
- `frame_error` out 1: one-cycle pulse when a frame is rejected.
- `pending` out 1: level; a valid shadow set is waiting for `sample_tick`.

## Operation
- **Synchronisation:** `sck`, `cs_n` and `mosi` each pass through a 2-flop synchroniser into `clk`. Edge detection runs on the synchronised `sck` and `cs_n`.
- **FSM states:** IDLE, RECV, CHECK.
  - IDLE -> RECV on a synchronised `cs_n` falling edge; clear `bit_cnt` to 0.
  - RECV: on each synchronised `sck` rising edge, shift `mosi` into an 80-bit receive register and increment `bit_cnt`. `bit_cnt` (7 bits) saturates at 81.
  - RECV -> CHECK on a synchronised `cs_n` rising edge.
  - CHECK (one cycle):
    - If `bit_cnt` == 80: load shadow from the receive register (b0 = bits [79:64] … a2 = bits [15:0]) and set `pending`.
    - Otherwise: pulse `frame_error`; shadow and `pending` are unchanged.
  - CHECK -> IDLE.
- **Commit:** when `sample_tick` = 1 and `pending` = 1:
  - active <= shadow;
  - `pending` <= 0;
  - pulse `coeff_updated`.
- `sample_tick` with `pending` = 0: no effect.
- **Latest wins:** a second valid frame before a tick overwrites the shadow; `pending` stays 1.
- **Simultaneous events:** CHECK (valid frame) in the same cycle as a commit-qualified `sample_tick`:
  - the commit takes the previous shadow;
  - the new shadow loads and `pending` stays 1;
  - the new frame commits on the next tick.
- **Errors:** an aborted or over-length frame (including `bit_cnt` 0) never touches the shadow or the active set.
- **No arithmetic:** coefficients pass through bit-exact; no clamping.

## Timing
- **Reset values (all asynchronous to `reset` low):**
  - b0 = 16'sh4000 (unity, 1.0 in Q2.14); b1 = b2 = a1 = a2 = 0;
  - `pending`, `coeff_updated`, `frame_error` = 0; FSM = IDLE; shadow = reset active values.
- **SPI constraints:**
  - `sck` high and low phases must each be ≥ 4 `clk` periods.
  - `cs_n` high time between frames must be ≥ 4 `clk` periods.
  - `mosi` must be stable ≥ 3 `clk` before the `sck` rising edge.
- **Latency:**
  - Pin `cs_n` rising edge to CHECK: 3 `clk` (2 synchroniser stages + edge register).
  - `pending` asserts 4 `clk` after the pin edge.
- **Commit:** `b0..a2` change on the `clk` edge after the `sample_tick` cycle; `coeff_updated` is high in that same cycle.
- **Reset mid-frame:** the partial frame is discarded and the outputs return to the unity set. After reset release, a frame already in progress is ignored until `cs_n` has been seen high and then falling.

## Structure
- **Shared package `iir_pkg`** (shared with the filter) holds:
  - `COEFF_W` = 16, `NUM_COEFFS` = 5, `FRAME_BITS` = 80, `Q2_14_ONE` = 16'sh4000;
  - `typedef logic signed [15:0] coeff_t`;
  - `typedef struct packed {coeff_t b0, b1, b2, a1, a2;} coeff_set_t`, used for the shadow and active sets.
- **Sub-module `sync_2ff`:** a single-bit 2-flop synchroniser with asynchronous active-low reset, instantiated 3×. Reset values: `cs_n` = 1, `sck` = 0, `mosi` = 0.

## Test plan
- **Reset:** hold `reset` low -> b0 = 0x4000, others 0, `pending` = 0, no pulses.
- **Valid frame:** send 0x2000, 0x1000, 0x0800, 0xC000, 0x0400, then `sample_tick` -> `pending` rises 4 `clk` after `cs_n` rise; the outputs hold those values the cycle after the tick; `coeff_updated` pulses once.
- **Short frame:** 79-bit frame -> `frame_error` pulses; `pending` stays 0; the outputs keep 0x4000/0/0/0/0. Repeat with an 81-bit frame -> same result.
- **Back-to-back frames:** frame A (b0 = 0x1111…) then frame B (b0 = 0x2222…) with no tick between, then a tick -> active set = B; exactly one `coeff_updated`.
- **Same-cycle collision:** pending frame A; frame B CHECK aligned with `sample_tick` -> A is committed and `pending` = 1; the next tick commits B.
- **Reset mid-frame:** assert `reset` low after 40 bits -> unity outputs. Release mid-`cs_n`-low -> the tail bits are ignored, no `frame_error`; the next full frame is accepted.
